// File: rtl/sc_io_ports.sv
// sc_io_ports
//   Memory-mapped I/O block for the single-cycle computer. It sits beside the
//   data memory on the CPU data bus and decodes a 128-byte region at IO_BASE
//   into word slots:
//     idx 0 .. NUM_IN-1      read-only, synchronised input ports
//     idx 16 .. 16+NUM_OUT-1 read/write output registers
//     idx 30                 STATUS change flags (write 1 to clear)
//     idx 31                 MASK for the interrupt line
//   Every other slot reads 0 and ignores writes. addr[1:0] is ignored.
//
// Optional feature (macro SC_IO_EDGE_IRQ_EN):
//   defined     - per-input change detect, STATUS/MASK registers and irq
//   not defined - no change detect; idx 30/31 read 0, irq tied low
//
// Ports:
//   clock      system clock, rising edge
//   resetn     asynchronous active-low reset
//   addr       byte address from the CPU
//   wdata      store data
//   we         store enable
//   io_sel     combinational region hit, steers the data-memory read mux
//   rdata      combinational read data, 0 outside the region
//   in_ports   asynchronous inputs, port i at [i*DATA_W +: DATA_W]
//   out_ports  registered outputs, same packing
//   irq        registered interrupt request
module sc_io_ports #(
  parameter int          DATA_W  = 32,
  parameter int          NUM_IN  = 4,
  parameter int          NUM_OUT = 4,
  parameter logic [31:0] IO_BASE = 32'h0000_0080
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [31:0]               addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      we,
  output logic                      io_sel,
  output logic [DATA_W-1:0]         rdata,
  input  logic [NUM_IN*DATA_W-1:0]  in_ports,
  output logic [NUM_OUT*DATA_W-1:0] out_ports,
  output logic                      irq
);

  localparam logic [4:0] IDX_OUT0   = 5'd16;
  localparam logic [4:0] IDX_STATUS = 5'd30;
  localparam logic [4:0] IDX_MASK   = 5'd31;

  logic [4:0] idx;
  logic       wr_en;
  logic [1:0] unused_byte_sel;

  assign idx             = addr[6:2];
  assign unused_byte_sel = addr[1:0];   // whole-word accesses only
  assign io_sel          = (addr[31:7] == IO_BASE[31:7]);
  assign wr_en           = we & io_sel;

  // ---- stage p0 / p1: two-flop synchroniser on every input port ----
  logic [NUM_IN*DATA_W-1:0] in_sync_p0;
  logic [NUM_IN*DATA_W-1:0] in_sync_p1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      in_sync_p0 <= '0;
      in_sync_p1 <= '0;
    end else begin
      in_sync_p0 <= in_ports;
      in_sync_p1 <= in_sync_p0;
    end
  end

  // Output registers, written when the word index selects them
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_ports <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (idx == IDX_OUT0 + 5'(i)) out_ports[i*DATA_W +: DATA_W] <= wdata;
      end
    end
  end

`ifdef SC_IO_EDGE_IRQ_EN
  // ---- stage p2: previous synchronised value for change detection ----
  logic [NUM_IN*DATA_W-1:0] prev_p2;
  logic [NUM_IN-1:0]        status_q;
  logic [NUM_IN-1:0]        mask_q;
  logic [NUM_IN-1:0]        chg;
  logic [NUM_IN-1:0]        clr;

  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      chg[i] = (in_sync_p1[i*DATA_W +: DATA_W] != prev_p2[i*DATA_W +: DATA_W]);
    end
  end

  assign clr = (wr_en && idx == IDX_STATUS) ? wdata[NUM_IN-1:0] : '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prev_p2  <= '0;
      status_q <= '0;
      mask_q   <= '0;
      irq      <= 1'b0;
    end else begin
      prev_p2  <= in_sync_p1;
      // OR-ing the new changes in after the clear lets a set win a collision
      status_q <= (status_q & ~clr) | chg;
      if (wr_en && idx == IDX_MASK) mask_q <= wdata[NUM_IN-1:0];
      irq      <= |(status_q & mask_q);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux: purely combinational from registers, so a same-cycle
  // read-after-write returns the old value
  always_comb begin
    rdata = '0;
    if (io_sel) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (idx == 5'(i)) rdata = in_sync_p1[i*DATA_W +: DATA_W];
      end
      for (int i = 0; i < NUM_OUT; i++) begin
        if (idx == IDX_OUT0 + 5'(i)) rdata = out_ports[i*DATA_W +: DATA_W];
      end
`ifdef SC_IO_EDGE_IRQ_EN
      if (idx == IDX_STATUS) rdata[NUM_IN-1:0] = status_q;
      if (idx == IDX_MASK)   rdata[NUM_IN-1:0] = mask_q;
`endif
    end
  end

endmodule

// File: tb/tb_sc_io_ports.sv
// Testbench for sc_io_ports: directed vector table, hand-written timing
// sequences and randomized traffic against a behavioural model.
module tb_sc_io_ports;

  localparam int DW = 32;
  localparam int NI = 4;
  localparam int NO = 4;

`ifdef SC_IO_EDGE_IRQ_EN
  localparam bit          EDGE_EN = 1'b1;
  localparam logic [31:0] MASK_RB = 32'hF;
`else
  localparam bit          EDGE_EN = 1'b0;
  localparam logic [31:0] MASK_RB = 32'h0;
`endif

  logic              clock = 1'b0;
  logic              resetn;
  logic [31:0]       addr;
  logic [DW-1:0]     wdata;
  logic              we;
  logic              io_sel;
  logic [DW-1:0]     rdata;
  logic [NI*DW-1:0]  in_ports;
  logic [NO*DW-1:0]  out_ports;
  logic              irq;

  sc_io_ports #(
    .DATA_W (DW),
    .NUM_IN (NI),
    .NUM_OUT(NO),
    .IO_BASE(32'h0000_0080)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .io_sel   (io_sel),
    .rdata    (rdata),
    .in_ports (in_ports),
    .out_ports(out_ports),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: architectural registers plus a short log of the pin
  // values seen at each clock edge since reset (newest last).
  logic [31:0]      m_out [NO];
  logic [NI-1:0]    m_status;
  logic [NI-1:0]    m_mask;
  logic             m_irq;
  logic [NI*DW-1:0] pin_log [$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_sel;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pin value sampled k edges ago (0 = most recent edge); 0 before reset release
  function automatic logic [NI*DW-1:0] seen(input int k);
    if (k >= pin_log.size()) return '0;
    return pin_log[pin_log.size()-1-k];
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < NO; j++) m_out[j] = '0;
    m_status = '0;
    m_mask   = '0;
    m_irq    = 1'b0;
    pin_log.delete();
  endfunction

  // Reads see the value that reached the pin two edges ago
  function automatic logic [31:0] m_read(input logic [31:0] a);
    int k;
    logic [NI*DW-1:0] s2;
    k  = int'(a[6:2]);
    s2 = seen(1);
    if (a[31:7] != 25'd1) return '0;
    if (k < NI) return s2[k*DW +: DW];
    if (k >= 16 && k < 16 + NO) return m_out[k-16];
    if (EDGE_EN && k == 30) return 32'(m_status);
    if (EDGE_EN && k == 31) return 32'(m_mask);
    return '0;
  endfunction

  function automatic logic [NO*DW-1:0] m_outs();
    logic [NO*DW-1:0] v;
    for (int j = 0; j < NO; j++) v[j*DW +: DW] = m_out[j];
    return v;
  endfunction

  // Apply the effect of the coming rising edge, using the current bus inputs
  function automatic void model_edge();
    int k;
    logic hit;
    logic [NI-1:0] set_b;
    logic [NI-1:0] clr_b;
    logic [NI*DW-1:0] s2;
    logic [NI*DW-1:0] pv;
    if (!resetn) return;
    k   = int'(addr[6:2]);
    hit = we && (addr[31:7] == 25'd1);
    s2  = seen(1);
    pv  = seen(2);
    if (hit && k >= 16 && k < 16 + NO) m_out[k-16] = wdata;
    if (EDGE_EN) begin
      for (int i = 0; i < NI; i++) set_b[i] = (s2[i*DW +: DW] != pv[i*DW +: DW]);
      clr_b    = (hit && k == 30) ? wdata[NI-1:0] : '0;
      m_irq    = |(m_status & m_mask);
      m_status = (m_status & ~clr_b) | set_b;
      if (hit && k == 31) m_mask = wdata[NI-1:0];
    end
    pin_log.push_back(in_ports);
    if (pin_log.size() > 3) void'(pin_log.pop_front());
  endfunction

  task automatic set_bus(input logic w, input logic [31:0] a, input logic [31:0] d);
    we    = w;
    addr  = a;
    wdata = d;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".io_sel"},    128'(io_sel),    128'(addr[31:7] == 25'd1));
    check({tag, ".rdata"},     128'(rdata),     128'(m_read(addr)));
    check({tag, ".out_ports"}, 128'(out_ports), 128'(m_outs()));
    check({tag, ".irq"},       128'(irq),       128'(m_irq));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [17];

    vecs[0]  = '{1'b1, 32'h0000_00C4, 32'hDEAD_BEEF, 32'h0,          1'b1};
    vecs[1]  = '{1'b0, 32'h0000_00C4, 32'h0,         32'hDEAD_BEEF,  1'b1};
    vecs[2]  = '{1'b0, 32'h0000_00C0, 32'h0,         32'h0,          1'b1};
    vecs[3]  = '{1'b1, 32'h0000_0100, 32'h5555,      32'h0,          1'b0};
    vecs[4]  = '{1'b0, 32'h0000_00C8, 32'h0,         32'h0,          1'b1};
    vecs[5]  = '{1'b1, 32'h0000_0094, 32'hAAAA,      32'h0,          1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0094, 32'h0,         32'h0,          1'b1};
    vecs[7]  = '{1'b1, 32'h0000_0080, 32'h77,        32'h0,          1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0080, 32'h0,         32'h0,          1'b1};
    vecs[9]  = '{1'b0, 32'h0000_00C7, 32'h0,         32'hDEAD_BEEF,  1'b1};
    vecs[10] = '{1'b1, 32'h0000_00CC, 32'h1234_5678, 32'h0,          1'b1};
    vecs[11] = '{1'b0, 32'h0000_00CC, 32'h0,         32'h1234_5678,  1'b1};
    vecs[12] = '{1'b1, 32'h0000_01C4, 32'h0,         32'h0,          1'b0};
    vecs[13] = '{1'b0, 32'h0000_00C4, 32'h0,         32'hDEAD_BEEF,  1'b1};
    vecs[14] = '{1'b0, 32'h0000_00F8, 32'h0,         32'h0,          1'b1};
    vecs[15] = '{1'b1, 32'h0000_00FC, 32'hF,         32'h0,          1'b1};
    vecs[16] = '{1'b0, 32'h0000_00FC, 32'h0,         MASK_RB,        1'b1};

    resetn   = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;
    in_ports = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    set_bus(1'b0, 32'h0000_00C0, 32'h0);
    check("reset.out_ports", 128'(out_ports), 128'h0);
    check("reset.irq",       128'(irq),       128'h0);
    check("reset.rdata_c0",  128'(rdata),     128'h0);
    resetn = 1'b1;
    tick();

    // Directed vector table: rdata is sampled before the edge that commits
    for (int i = 0; i < 17; i++) begin
      set_bus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d.rdata", i),  128'(rdata),  128'(vecs[i].exp_rdata));
      check($sformatf("vec%0d.io_sel", i), 128'(io_sel), 128'(vecs[i].exp_sel));
      check_model($sformatf("vec%0d", i));
      tick();
    end
    check("vec.out_port1", 128'(out_ports[63:32]), 128'hDEAD_BEEF);
    check("vec.out_all",   128'(out_ports),
          128'({32'h1234_5678, 32'h0, 32'hDEAD_BEEF, 32'h0}));

    // Input latency: change before edge N, visible after edge N+1
    in_ports[31:0] = 32'h1234;
    set_bus(1'b0, 32'h0000_0080, 32'h0);
    check("lat.before", 128'(rdata), 128'h0);
    tick();
    check("lat.edge_n", 128'(rdata), 128'h0);
    tick();
    check("lat.edge_n1", 128'(rdata), 128'h1234);
    check_model("lat");

`ifdef SC_IO_EDGE_IRQ_EN
    // Change flag and interrupt timing
    repeat (3) begin
      set_bus(1'b0, 32'h0000_00F8, 32'h0);
      tick();
    end
    set_bus(1'b1, 32'h0000_00F8, 32'hF);
    tick();
    set_bus(1'b1, 32'h0000_00FC, 32'h1);
    tick();
    set_bus(1'b0, 32'h0000_00F8, 32'h0);
    check("flag.cleared", 128'(rdata), 128'h0);
    check("flag.irq_idle", 128'(irq), 128'h0);
    in_ports[31:0] = 32'h1234 ^ 32'hFFFF;
    tick();
    check("flag.edge_n", 128'(rdata), 128'h0);
    tick();
    check("flag.edge_n1", 128'(rdata), 128'h0);
    tick();
    check("flag.edge_n2", 128'(rdata), 128'h1);
    check("flag.irq_n2", 128'(irq), 128'h0);
    tick();
    check("flag.irq_n3", 128'(irq), 128'h1);
    check_model("flag");
    set_bus(1'b1, 32'h0000_00F8, 32'h1);
    check("w1c.read_old", 128'(rdata), 128'h1);
    tick();
    set_bus(1'b0, 32'h0000_00F8, 32'h0);
    check("w1c.status", 128'(rdata), 128'h0);
    check("w1c.irq_hold", 128'(irq), 128'h1);
    tick();
    check("w1c.irq_drop", 128'(irq), 128'h0);
    check_model("w1c");

    // Set and clear on the same edge: set wins
    in_ports[31:0] = 32'h0000_00C1;
    set_bus(1'b0, 32'h0000_00F8, 32'h0);
    tick();
    tick();
    in_ports[31:0] = 32'h0000_00C2;
    tick();
    check("simul.first_set", 128'(rdata), 128'h1);
    tick();
    set_bus(1'b1, 32'h0000_00F8, 32'h1);
    tick();
    set_bus(1'b0, 32'h0000_00F8, 32'h0);
    check("simul.set_wins", 128'(rdata), 128'h1);
    check_model("simul");
`else
    // Without the feature, STATUS/MASK slots are inert and irq stays low
    set_bus(1'b1, 32'h0000_00F8, 32'hF);
    tick();
    set_bus(1'b1, 32'h0000_00FC, 32'hF);
    tick();
    set_bus(1'b0, 32'h0000_00F8, 32'h0);
    check("noirq.status", 128'(rdata), 128'h0);
    set_bus(1'b0, 32'h0000_00FC, 32'h0);
    check("noirq.mask", 128'(rdata), 128'h0);
    check("noirq.irq", 128'(irq), 128'h0);
    repeat (3) tick();
    check("noirq.irq_later", 128'(irq), 128'h0);
`endif

    // Reset asserted mid-operation with a write in flight
    set_bus(1'b1, 32'h0000_00C0, 32'hCAFE_F00D);
    tick();
    set_bus(1'b1, 32'h0000_00FC, 32'hF);
    tick();
    set_bus(1'b1, 32'h0000_00C0, 32'h5A5A_5A5A);
    check_model("pre_rst");
    resetn = 1'b0;
    #1;
    model_reset();
    check("rst.out_ports", 128'(out_ports), 128'h0);
    check("rst.irq",       128'(irq),       128'h0);
    check("rst.rd_idx16",  128'(rdata),     128'h0);
    set_bus(1'b0, 32'h0000_00F8, 32'h0);
    check("rst.rd_idx30", 128'(rdata), 128'h0);
    set_bus(1'b0, 32'h0000_00FC, 32'h0);
    check("rst.rd_idx31", 128'(rdata), 128'h0);
    set_bus(1'b1, 32'h0000_00C0, 32'h5A5A_5A5A);
    tick();
    check("rst.write_lost", 128'(out_ports), 128'h0);
    resetn = 1'b1;
    set_bus(1'b0, 32'h0000_00C0, 32'h0);
    check("rel.rd_idx16", 128'(rdata), 128'h0);
    set_bus(1'b0, 32'h0000_00F8, 32'h0);
    check("rel.rd_idx30", 128'(rdata), 128'h0);
    set_bus(1'b0, 32'h0000_00FC, 32'h0);
    check("rel.rd_idx31", 128'(rdata), 128'h0);
    check("rel.irq", 128'(irq), 128'h0);
    tick();
    check_model("rel");

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic [31:0] a;
      int p;
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(0, NI-1);
        in_ports[p*DW +: DW] = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'(p + 1);
      end
      if ($urandom_range(0, 7) < 6) begin
        a = {25'd1, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
      end else begin
        a = $urandom;
        if (a[31:7] == 25'd1) a[31] = 1'b1;
      end
      set_bus(1'($urandom_range(0, 1)), a, 32'($urandom));
      check_model($sformatf("rnd%0d", c));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
